hdmi_text_render: RTL and testbench

HDMI_TEXT_RENDER -- requirements
Module: hdmi_text_render

---
 rtl/hdmi_text_render.sv | 169 ++++++++++++++++
 tb/tb_hdmi_text_render.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/hdmi_text_render.sv
// Text-mode pixel renderer: turns cell coordinates from the text-mode timing stage into
// 24-bit RGB video. Three pipeline stages line up with the synchronous text RAM and font ROM
// reads, and the timing signals are delayed to stay bit-aligned with the colour.
module hdmi_text_render #(
    parameter int unsigned CURSOR_FIRST_LINE = 18
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_active,
    input  logic        in_h_sync,
    input  logic        in_v_sync,
    input  logic [4:0]  in_row,
    input  logic [4:0]  in_row_pixel,
    input  logic [6:0]  in_col,
    input  logic [3:0]  in_col_pixel,
    input  logic        cursor_enable,
    input  logic [4:0]  cursor_row,
    input  logic [6:0]  cursor_col,
    output logic [11:0] char_addr,
    input  logic [15:0] char_data,
    output logic [12:0] font_addr,
    input  logic [9:0]  font_data,
    output logic        out_active,
    output logic        out_h_sync,
    output logic        out_v_sync,
    output logic [23:0] out_rgb
);

    // Stage 1 registers
    logic [4:0] s1_row_pixel;
    logic [3:0] s1_col_pixel;
    logic       s1_active;
    logic       s1_h_sync;
    logic       s1_v_sync;
    logic       s1_cursor;

    // Stage 2 registers
    logic [3:0] s2_fg;
    logic [2:0] s2_bg;
    logic       s2_blink;
    logic [3:0] s2_col_pixel;
    logic       s2_active;
    logic       s2_h_sync;
    logic       s2_v_sync;
    logic       s2_cursor;

    // Frame counter and v_sync edge detector
    logic       v_sync_prev;
    logic [4:0] frame_cnt;
    logic       blink_phase;

    logic       cursor_hit;
    logic       glyph_bit;
    logic       final_bit;
    logic [3:0] colour_idx;
    logic [23:0] pixel_rgb;

    // Map an index bit and the intensity bit onto one 8-bit colour component.
    function automatic logic [7:0] palette_comp(input logic b, input logic i);
        logic [7:0] c;
        unique case ({b, i})
            2'b11:   c = 8'hFF;
            2'b10:   c = 8'hAA;
            2'b01:   c = 8'h55;
            default: c = 8'h00;
        endcase
        return c;
    endfunction

    assign char_addr   = {in_row, in_col};
    assign font_addr   = {char_data[7:0], s1_row_pixel};
    assign blink_phase = frame_cnt[4];

    // Cursor compares raw buffer row so it follows scrolled content, not the screen row.
    always_comb begin
        cursor_hit = cursor_enable && (in_row == cursor_row) && (in_col == cursor_col) &&
                     ({27'd0, in_row_pixel} >= CURSOR_FIRST_LINE);
    end

    // Stage 3 pixel selection: glyph bit, blink masking, cursor inversion, palette lookup.
    always_comb begin
        glyph_bit = 1'b0;
        if (s2_col_pixel <= 4'd9) begin
            glyph_bit = font_data[4'd9 - s2_col_pixel];
        end
        if (s2_blink && !blink_phase) begin
            glyph_bit = 1'b0;
        end
        final_bit  = glyph_bit ^ (s2_cursor && blink_phase);
        colour_idx = final_bit ? s2_fg : {1'b0, s2_bg};
        pixel_rgb  = {palette_comp(colour_idx[2], colour_idx[3]),
                      palette_comp(colour_idx[1], colour_idx[3]),
                      palette_comp(colour_idx[0], colour_idx[3])};
        if (!s2_active) begin
            pixel_rgb = 24'h000000;
        end
    end

    // Stage 1: capture coordinates, timing and the cursor hit alongside the text RAM read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_row_pixel <= '0;
            s1_col_pixel <= '0;
            s1_active    <= 1'b0;
            s1_h_sync    <= 1'b0;
            s1_v_sync    <= 1'b0;
            s1_cursor    <= 1'b0;
        end else begin
            s1_row_pixel <= in_row_pixel;
            s1_col_pixel <= in_col_pixel;
            s1_active    <= in_active;
            s1_h_sync    <= in_h_sync;
            s1_v_sync    <= in_v_sync;
            s1_cursor    <= cursor_hit;
        end
    end

    // Stage 2: capture the character attributes while the font ROM read is in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_fg        <= '0;
            s2_bg        <= '0;
            s2_blink     <= 1'b0;
            s2_col_pixel <= '0;
            s2_active    <= 1'b0;
            s2_h_sync    <= 1'b0;
            s2_v_sync    <= 1'b0;
            s2_cursor    <= 1'b0;
        end else begin
            s2_fg        <= char_data[11:8];
            s2_bg        <= char_data[14:12];
            s2_blink     <= char_data[15];
            s2_col_pixel <= s1_col_pixel;
            s2_active    <= s1_active;
            s2_h_sync    <= s1_h_sync;
            s2_v_sync    <= s1_v_sync;
            s2_cursor    <= s1_cursor;
        end
    end

    // Stage 3: registered video outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_active <= 1'b0;
            out_h_sync <= 1'b0;
            out_v_sync <= 1'b0;
            out_rgb    <= 24'h000000;
        end else begin
            out_active <= s2_active;
            out_h_sync <= s2_h_sync;
            out_v_sync <= s2_v_sync;
            out_rgb    <= pixel_rgb;
        end
    end

    // Count frames on each rising edge of the raw input v_sync; wraps naturally at 32.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v_sync_prev <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            v_sync_prev <= in_v_sync;
            if (in_v_sync && !v_sync_prev) begin
                frame_cnt <= frame_cnt + 5'd1;
            end
        end
    end

endmodule

// File: tb/tb_hdmi_text_render.sv
// Self-checking bench for hdmi_text_render: random cell/timing stimulus against a
// behavioural model of the rendered pixel, with synchronous text RAM and font ROM models.
module tb_hdmi_text_render;

    localparam int CFL = 18;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_active = 1'b0, in_h_sync = 1'b0, in_v_sync = 1'b0;
    logic [4:0]  in_row = '0, in_row_pixel = '0;
    logic [6:0]  in_col = '0;
    logic [3:0]  in_col_pixel = '0;
    logic        cursor_enable = 1'b0;
    logic [4:0]  cursor_row = '0;
    logic [6:0]  cursor_col = '0;
    logic [11:0] char_addr;
    logic [15:0] char_data = '0;
    logic [12:0] font_addr;
    logic [9:0]  font_data = '0;
    logic        out_active, out_h_sync, out_v_sync;
    logic [23:0] out_rgb;

    logic [15:0] ram [4096];
    logic [9:0]  font [8192];

    typedef struct {
        bit       act, hs, vs;
        bit [4:0] row, rp;
        bit [6:0] col;
        bit [3:0] cp;
        bit       cen;
        bit [4:0] crow;
        bit [6:0] ccol;
    } smp_t;

    smp_t hist[$];
    int   fcq[$];
    int   fc;
    bit   vprev;
    int   checks = 0;
    int   failures = 0;

    hdmi_text_render #(.CURSOR_FIRST_LINE(CFL)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_active(in_active), .in_h_sync(in_h_sync), .in_v_sync(in_v_sync),
        .in_row(in_row), .in_row_pixel(in_row_pixel), .in_col(in_col),
        .in_col_pixel(in_col_pixel),
        .cursor_enable(cursor_enable), .cursor_row(cursor_row), .cursor_col(cursor_col),
        .char_addr(char_addr), .char_data(char_data),
        .font_addr(font_addr), .font_data(font_data),
        .out_active(out_active), .out_h_sync(out_h_sync), .out_v_sync(out_v_sync),
        .out_rgb(out_rgb)
    );

    always #5 clk = ~clk;

    // Synchronous text RAM and font ROM: data valid one cycle after the address.
    always @(posedge clk) begin
        char_data <= ram[char_addr];
        font_data <= font[font_addr];
    end

    function automatic logic [23:0] pal(input logic [3:0] idx);
        logic [23:0] v;
        for (int k = 0; k < 3; k++) begin
            int lvl;
            lvl = (idx[k] ? 8'hAA : 0) + (idx[3] ? 8'h55 : 0);
            v[k*8 +: 8] = 8'(lvl);
        end
        return v;
    endfunction

    // Expected pixel for one input sample given the frame count seen by the output stage.
    function automatic logic [23:0] exp_rgb(input smp_t s, input int fcv);
        logic [15:0] w;
        logic [9:0]  g;
        bit          b, phase, hit;
        logic [3:0]  idx;
        w     = ram[{s.row, s.col}];
        g     = font[{w[7:0], s.rp}];
        b     = g[9 - int'(s.cp)];
        phase = (fcv >= 16);
        if (w[15] && !phase) b = 1'b0;
        hit = s.cen && (s.row == s.crow) && (s.col == s.ccol) && (int'(s.rp) >= CFL);
        if (hit && phase) b = !b;
        idx = b ? w[11:8] : {1'b0, w[14:12]};
        return s.act ? pal(idx) : 24'h000000;
    endfunction

    task automatic chk(input string tag, input logic [23:0] got, input logic [23:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        hist.delete();
        fcq.delete();
        fc    = 0;
        vprev = 1'b0;
    endtask

    // Drive one sample, clock it in, update the model and compare all outputs.
    task automatic step(input smp_t s);
        smp_t e;
        int   n;
        @(negedge clk);
        in_active = s.act; in_h_sync = s.hs; in_v_sync = s.vs;
        in_row = s.row; in_row_pixel = s.rp; in_col = s.col; in_col_pixel = s.cp;
        cursor_enable = s.cen; cursor_row = s.crow; cursor_col = s.ccol;
        reset_n = 1'b1;
        @(posedge clk);
        hist.push_back(s);
        if (s.vs && !vprev) fc = (fc + 1) % 32;
        vprev = s.vs;
        fcq.push_back(fc);
        if (hist.size() > 4) begin
            void'(hist.pop_front());
            void'(fcq.pop_front());
        end
        #1;
        n = hist.size();
        if (n >= 3) begin
            e = hist[n-3];
            chk("active", {23'd0, out_active}, {23'd0, e.act});
            chk("h_sync", {23'd0, out_h_sync}, {23'd0, e.hs});
            chk("v_sync", {23'd0, out_v_sync}, {23'd0, e.vs});
            chk("rgb", out_rgb, exp_rgb(e, fcq[n-2]));
        end else begin
            chk("fill_active", {23'd0, out_active}, 24'd0);
            chk("fill_rgb", out_rgb, 24'd0);
        end
    endtask

    function automatic smp_t rnd();
        smp_t s;
        s.act  = ($urandom_range(0, 3) != 0);
        s.hs   = 1'($urandom_range(0, 1));
        s.vs   = 1'($urandom_range(0, 1));
        s.row  = 5'($urandom_range(0, 3));
        s.col  = 7'($urandom_range(0, 3));
        s.rp   = 5'($urandom_range(0, 19));
        s.cp   = 4'($urandom_range(0, 9));
        s.cen  = ($urandom_range(0, 3) != 0);
        s.crow = 5'($urandom_range(0, 3));
        s.ccol = 7'($urandom_range(0, 3));
        return s;
    endfunction

    task automatic check_reset_state(input string tag);
        chk({tag, "_active"}, {23'd0, out_active}, 24'd0);
        chk({tag, "_h_sync"}, {23'd0, out_h_sync}, 24'd0);
        chk({tag, "_v_sync"}, {23'd0, out_v_sync}, 24'd0);
        chk({tag, "_rgb"}, out_rgb, 24'd0);
    endtask

    initial begin
        smp_t s;
        for (int i = 0; i < 4096; i++) ram[i] = 16'($urandom);
        for (int i = 0; i < 8192; i++) font[i] = 10'($urandom);
        // Known glyph row: 'A' white on blue, border pixels set.
        ram[{5'd1, 7'd1}]    = {1'b0, 3'h1, 4'hF, 8'h41};
        font[{8'h41, 5'd2}]  = 10'b1000000001;

        model_clear();
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");

        // Directed glyph row, blink off, cursor off.
        for (int c = 0; c < 10; c++) begin
            s = '{act: 1'b1, hs: 1'b0, vs: 1'b0, row: 5'd1, rp: 5'd2, col: 7'd1,
                  cp: 4'(c), cen: 1'b0, crow: 5'd0, ccol: 7'd0};
            step(s);
        end
        s.act = 1'b0;
        repeat (3) step(s);

        for (int i = 0; i < 500; i++) step(rnd());

        // Asynchronous reset mid-line must blank outputs before the next edge.
        #2 reset_n = 1'b0;
        #1;
        check_reset_state("async_reset");
        model_clear();
        repeat (2) @(posedge clk);

        for (int i = 0; i < 500; i++) step(rnd());

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
